// File: rtl/sdf_fft_pkg.sv
// Shared SDF FFT definitions: default sizes, bit-reverse helper and read FSM encoding.
// Used by the twiddle generator, the stage units and the output reorder buffer.
package sdf_fft_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int N_DEF     = 256;
    localparam int REV_W     = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // Reverses the low `bits` bits of v; upper bits return zero.
    function automatic logic [REV_W-1:0] bitrev(
        input logic [REV_W-1:0] v,
        input int               bits
    );
        logic [REV_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_W; i++) begin
            if (i < bits) r[i] = v[bits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_pingpong_ram.sv
// Two-bank frame store: one write port, one registered read port.
// The address MSB selects the bank.
module sdf_pingpong_ram
    import sdf_fft_pkg::*;
#(
    parameter int DW = 2 * WIDTH_DEF,
    parameter int AW = 9
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Reorders the bit-reversed SDF FFT output frame into natural bin order.
// Optional REORDER_FRAME_FLAGS_EN adds output_sof/output_eof frame markers.
module sdf_bitrev_reorder
    import sdf_fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = N_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real,
    input  logic [WIDTH-1:0] input_imag,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real,
`ifdef REORDER_FRAME_FLAGS_EN
    output logic [WIDTH-1:0] output_imag,
    output logic             output_sof,
    output logic             output_eof
`else
    output logic [WIDTH-1:0] output_imag
`endif
);

    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [0:0]       state_q, state_d;

    logic             rd_vld_q;
    logic             rd_sof_q;
    logic             rd_eof_q;
    logic             out_en_q;
    logic [WIDTH-1:0] out_re_q;
    logic [WIDTH-1:0] out_im_q;
    logic             out_sof_q;
    logic             out_eof_q;

    logic             wr_last;
    logic             rd_go;
    logic             rd_last;
    logic             set_full;
    logic             clr_full;
    logic             other_full;
    logic [REV_W-1:0] wr_rev;
    logic             unused_rev;
    logic [2*WIDTH-1:0] rdata;

    assign wr_rev = bitrev({{(REV_W-LOG2N){1'b0}}, wr_cnt_q}, LOG2N);
    assign unused_rev = ^wr_rev[REV_W-1:LOG2N];

    assign wr_last  = input_en && (wr_cnt_q == LAST);
    assign rd_go    = (state_q == ST_READ) || full_q[rd_bank_q];
    assign rd_last  = rd_go && (rd_cnt_q == LAST);
    assign set_full = wr_last;
    assign clr_full = rd_last;

    // A frame completing in the other bank this cycle keeps reads seamless.
    assign other_full = full_q[~rd_bank_q]
                     || (set_full && (wr_bank_q != rd_bank_q));

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (input_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_last) wr_bank_d = ~wr_bank_q;
        end
    end

    // Set after clear so a set to the same bank dominates.
    always_comb begin
        full_d = full_q;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
        if (set_full) full_d[wr_bank_q] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        if (rd_go) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            state_d  = ST_READ;
            if (rd_last) begin
                rd_bank_d = ~rd_bank_q;
                state_d   = other_full ? ST_READ : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            state_q   <= ST_IDLE;
            rd_vld_q  <= 1'b0;
            rd_sof_q  <= 1'b0;
            rd_eof_q  <= 1'b0;
            out_en_q  <= 1'b0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_sof_q <= 1'b0;
            out_eof_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_vld_q  <= rd_go;
            rd_sof_q  <= rd_go && (rd_cnt_q == '0);
            rd_eof_q  <= rd_last;
            out_en_q  <= rd_vld_q;
            out_sof_q <= rd_vld_q && rd_sof_q;
            out_eof_q <= rd_vld_q && rd_eof_q;
            if (rd_vld_q) begin
                out_re_q <= rdata[WIDTH-1:0];
                out_im_q <= rdata[2*WIDTH-1:WIDTH];
            end
        end
    end

    sdf_pingpong_ram #(
        .DW (2 * WIDTH),
        .AW (LOG2N + 1)
    ) u_ram (
        .clock   (clock),
        .we_i    (input_en),
        .waddr_i ({wr_bank_q, wr_rev[LOG2N-1:0]}),
        .wdata_i ({input_imag, input_real}),
        .re_i    (rd_go),
        .raddr_i ({rd_bank_q, rd_cnt_q}),
        .rdata_o (rdata)
    );

    assign output_en   = out_en_q;
    assign output_real = out_re_q;
    assign output_imag = out_im_q;

`ifdef REORDER_FRAME_FLAGS_EN
    assign output_sof = out_sof_q;
    assign output_eof = out_eof_q;
`else
    logic unused_flags;
    assign unused_flags = out_sof_q ^ out_eof_q;
`endif

endmodule
